// File: rtl/decode_exec_stage_pkg.sv
// Shared definitions for the decode/execute stage.
// Contents: RV32I opcode/funct3/funct7 constants for the supported subset,
// the FSM state encoding, the ALU operation encoding and the ALU helper.
package decode_exec_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_LWB
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLT
    } alu_op_e;

    function automatic logic [DATA_W-1:0] alu_eval(input alu_op_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: alu_eval = a + b;
            ALU_SUB: alu_eval = a - b;
            ALU_XOR: alu_eval = a ^ b;
            ALU_OR:  alu_eval = a | b;
            ALU_AND: alu_eval = a & b;
            ALU_SLT: alu_eval = {{(DATA_W-1){1'b0}}, (sa < sb)};
            default: alu_eval = '0;
        endcase
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register file for the decode/execute stage.
// Ports: clk_i, rst_ni (async active-low clear of every entry),
//        raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o (combinational reads),
//        we_i/waddr_i/wdata_i (write on posedge).
// With ZERO_REG=1 entry 0 reads as zero and writes to it are dropped.
module exec_regfile #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_blocked;

    assign wr_blocked = (ZERO_REG != 0) && (waddr_i == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && !wr_blocked) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = ((ZERO_REG != 0) && (raddr_a_i == '0)) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = ((ZERO_REG != 0) && (raddr_b_i == '0)) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/decode_exec_stage.sv
// Decode/execute stage for a small RV32I subset, one instruction in flight.
// Ports: clk, rst (async active-low), instrValid/instrIn/pcIn from fetch,
//        memRdata (load data, valid the cycle after memRe),
//        memAddr/memWdata/memWe/memRe towards the unified memory,
//        busy (not idle), done/pcNext/illegal on retirement.
// All strobes and done are registered one-cycle pulses.
module decode_exec_stage
    import decode_exec_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instrValid,
    input  logic [31:0]       instrIn,
    input  logic [31:0]       pcIn,
    input  logic [DATA_W-1:0] memRdata,
    output logic [31:0]       memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              memWe,
    output logic              memRe,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pcNext,
    output logic              illegal
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    state_e            state_q;
    logic [31:0]       instr_q;
    logic [31:0]       pc_q;
    logic [31:0]       mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic              done_q;
    logic [31:0]       pc_next_q;
    logic              illegal_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd_f;
    logic [4:0]        rs1_f;
    logic [4:0]        rs2_f;
    logic [31:0]       imm_i;
    logic [31:0]       imm_s;
    logic [31:0]       imm_b;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    alu_op_e           alu_op;
    logic              alu_legal;
    logic              use_imm;
    logic              is_lw;
    logic              is_sw;
    logic              is_beq;
    logic [DATA_W-1:0] alu_res;
    logic [31:0]       ls_addr;
    logic              misaligned;
    logic              illegal_d;
    logic              beq_taken;
    logic [31:0]       pc_next_d;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign opcode = instr_q[6:0];
    assign rd_f   = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1_f  = instr_q[19:15];
    assign rs2_f  = instr_q[24:20];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};

    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b0;
        use_imm   = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    alu_legal = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: alu_op = ALU_ADD;
                        F3_XOR:     alu_op = ALU_XOR;
                        F3_OR:      alu_op = ALU_OR;
                        F3_AND:     alu_op = ALU_AND;
                        F3_SLT:     alu_op = ALU_SLT;
                        default:    alu_legal = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
                    alu_legal = 1'b1;
                    alu_op    = ALU_SUB;
                end
            end
            OP_ADDI: begin
                alu_legal = (funct3 == F3_ADD_SUB);
                use_imm   = 1'b1;
            end
            OP_LOAD:   is_lw  = (funct3 == F3_LW);
            OP_STORE:  is_sw  = (funct3 == F3_SW);
            OP_BRANCH: is_beq = (funct3 == F3_BEQ);
            default: ;
        endcase
    end

    exec_regfile #(
        .DATA_W   (DATA_W),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst),
        .raddr_a_i (rs1_f[AW-1:0]),
        .rdata_a_o (rs1_data),
        .raddr_b_i (rs2_f[AW-1:0]),
        .rdata_b_o (rs2_data),
        .we_i      (rf_we),
        .waddr_i   (rd_f[AW-1:0]),
        .wdata_i   (rf_wdata)
    );

    assign alu_res    = alu_eval(alu_op, rs1_data, use_imm ? imm_i : rs2_data);
    assign ls_addr    = rs1_data + (is_sw ? imm_s : imm_i);
    assign misaligned = (is_lw || is_sw) && (ls_addr[1:0] != 2'b00);
    // Unknown encodings and misaligned accesses retire the same way: flag only.
    assign illegal_d  = !(alu_legal || is_lw || is_sw || is_beq) || misaligned;
    assign beq_taken  = is_beq && (rs1_data == rs2_data);
    assign pc_next_d  = beq_taken ? (pc_q + imm_b) : (pc_q + 32'd4);

    // Register writes happen at the edge leaving EXEC (ALU) or LWB (load).
    assign rf_we    = ((state_q == ST_EXEC) && alu_legal) || (state_q == ST_LWB);
    assign rf_wdata = (state_q == ST_LWB) ? memRdata : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            done_q      <= 1'b0;
            pc_next_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instrValid) begin
                        instr_q <= instrIn;
                        pc_q    <= pcIn;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_lw && !misaligned) begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= ls_addr;
                        state_q    <= ST_MEM;
                    end else begin
                        done_q    <= 1'b1;
                        illegal_q <= illegal_d;
                        pc_next_q <= pc_next_d;
                        if (is_sw && !misaligned) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= rs2_data;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                // Memory answers one cycle after the read strobe.
                ST_MEM: state_q <= ST_LWB;
                ST_LWB: begin
                    done_q    <= 1'b1;
                    pc_next_q <= pc_q + 32'd4;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign memWe    = mem_we_q;
    assign memRe    = mem_re_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign pcNext   = pc_next_q;
    assign illegal  = illegal_q;

endmodule
